// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ALU control codes and datapath select codes.
package mc_ctrl_pkg;

    localparam int STATE_W   = 4;
    localparam int ALUCTRL_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
// The controller only produces outputs; it never stalls on the datapath, so there is no handshake.
interface multicycle_control_if;
    import mc_ctrl_pkg::*;

    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 zero;
    logic                 PCEn;
    logic                 IorD;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 RegWrite;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [1:0]           PCSrc;
    logic                 instr_done;
    logic                 illegal_op;
    state_t               state;

    modport master (
        input  opcode, funct, zero,
        output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, instr_done, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero,
        input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, instr_done, illegal_op, state
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: aluop selects add, sub, or the R-type funct mapping.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  aluop_t               aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown functs fall back to add without flagging anything.
                case (funct)
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore controller FSM for the multicycle MIPS datapath. Define CTRL_BNE_EN to add bne
// (opcode 000101) as a branch on not-equal; otherwise that opcode is illegal.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    state_t state, state_next, state_eff, decode_target;
    aluop_t aluop;
    logic   pc_write, branch, is_bne;
    logic   iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic   done, illegal;
    logic [1:0] alu_src_b, pc_src;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        decode_target = S_FETCH;
        is_bne        = 1'b0;
        case (bus.opcode)
            OP_LW, OP_SW: decode_target = S_MEMADR;
            OP_RTYPE:     decode_target = S_EXECUTE;
            OP_BEQ:       decode_target = S_BRANCH;
            OP_ADDI:      decode_target = S_ADDIEX;
            OP_J:         decode_target = S_JUMP;
`ifdef CTRL_BNE_EN
            OP_BNE: begin
                decode_target = S_BRANCH;
                is_bne        = 1'b1;
            end
`endif
            default:      decode_target = S_FETCH;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = S_DECODE;
            S_DECODE:  state_next = decode_target;
            S_MEMADR:  state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // While in reset the selects show the FETCH decode; enables are masked below.
    assign state_eff = rst_n ? state : S_FETCH;

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        aluop      = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state_eff)
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                illegal   = (decode_target == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                done       = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                done      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
                done      = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    mc_alu_decoder u_alu_dec (
        .aluop       (aluop),
        .funct       (bus.funct),
        .alu_control (bus.ALUControl)
    );

    // bne reuses BRANCH; only the zero polarity differs.
    assign bus.PCEn       = rst_n & (pc_write | (branch & (bus.zero ^ is_bne)));
    assign bus.IorD       = iord;
    assign bus.MemWrite   = rst_n & mem_write;
    assign bus.IRWrite    = rst_n & ir_write;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.RegWrite   = rst_n & reg_write;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.PCSrc      = pc_src;
    assign bus.instr_done = rst_n & done;
    assign bus.illegal_op = rst_n & illegal;
    assign bus.state      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each task walks one instruction through the FSM
// and checks the control outputs cycle by cycle against hand-derived values.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.opcode = OP_RTYPE;
        bus.funct  = FN_ADD;
        bus.zero   = 1'b0;
        next_cycle();
        next_cycle();
        checks++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL rst_state: got %0d expected %0d", bus.state, S_FETCH); end
        checks++; if (bus.PCEn !== 1'b0) begin errors++; $display("FAIL rst_pcen: got %b expected 0", bus.PCEn); end
        checks++; if (bus.IRWrite !== 1'b0) begin errors++; $display("FAIL rst_irwrite: got %b expected 0", bus.IRWrite); end
        checks++; if (bus.ALUSrcB !== 2'b01) begin errors++; $display("FAIL rst_srcb: got %b expected 01", bus.ALUSrcB); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.IRWrite !== 1'b1) begin errors++; $display("FAIL rel_irwrite: got %b expected 1", bus.IRWrite); end
        next_cycle();
        next_cycle();
        checks++; if (bus.state !== S_EXECUTE) begin errors++; $display("FAIL pre_rst_exec: got %0d expected %0d", bus.state, S_EXECUTE); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL midrst_regwrite0: got %b expected 0", bus.RegWrite); end
        checks++; if (bus.ALUSrcB !== 2'b01) begin errors++; $display("FAIL midrst_srcb: got %b expected 01", bus.ALUSrcB); end
        next_cycle();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL midrst_regwrite1: got %b expected 0", bus.RegWrite); end
        checks++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", bus.state, S_FETCH); end
        next_cycle();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL midrst_regwrite2: got %b expected 0", bus.RegWrite); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.IRWrite !== 1'b1) begin errors++; $display("FAIL post_rst_irwrite: got %b expected 1", bus.IRWrite); end
        checks++; if (bus.PCEn !== 1'b1) begin errors++; $display("FAIL post_rst_pcen: got %b expected 1", bus.PCEn); end
        checks++; if (bus.ALUSrcB !== 2'b01) begin errors++; $display("FAIL post_rst_srcb: got %b expected 01", bus.ALUSrcB); end
    endtask

    task automatic test_lw;
        bus.opcode = OP_LW;
        #1;
        checks++; if (bus.instr_done !== 1'b0) begin errors++; $display("FAIL lw_c1_done: got %b expected 0", bus.instr_done); end
        next_cycle();
        checks++; if (bus.state !== S_DECODE) begin errors++; $display("FAIL lw_c2_state: got %0d expected %0d", bus.state, S_DECODE); end
        checks++; if (bus.ALUSrcB !== 2'b11) begin errors++; $display("FAIL lw_c2_srcb: got %b expected 11", bus.ALUSrcB); end
        next_cycle();
        checks++; if (bus.state !== S_MEMADR) begin errors++; $display("FAIL lw_c3_state: got %0d expected %0d", bus.state, S_MEMADR); end
        checks++; if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl} !== 6'b1_10_010) begin errors++; $display("FAIL lw_c3_alu: got %b expected 110010", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}); end
        next_cycle();
        checks++; if (bus.state !== S_MEMRD) begin errors++; $display("FAIL lw_c4_state: got %0d expected %0d", bus.state, S_MEMRD); end
        checks++; if ({bus.IorD, bus.RegWrite, bus.instr_done} !== 3'b100) begin errors++; $display("FAIL lw_c4_ctl: got %b expected 100", {bus.IorD, bus.RegWrite, bus.instr_done}); end
        next_cycle();
        checks++; if (bus.state !== S_MEMWB) begin errors++; $display("FAIL lw_c5_state: got %0d expected %0d", bus.state, S_MEMWB); end
        checks++; if ({bus.RegWrite, bus.MemtoReg, bus.RegDst, bus.instr_done} !== 4'b1101) begin errors++; $display("FAIL lw_c5_ctl: got %b expected 1101", {bus.RegWrite, bus.MemtoReg, bus.RegDst, bus.instr_done}); end
        next_cycle();
        checks++; if ({bus.state, bus.instr_done} !== {S_FETCH, 1'b0}) begin errors++; $display("FAIL lw_end: got %0d/%b expected 0/0", bus.state, bus.instr_done); end
    endtask

    task automatic test_sw;
        bus.opcode = OP_SW;
        next_cycle();
        next_cycle();
        checks++; if (bus.state !== S_MEMADR) begin errors++; $display("FAIL sw_c3_state: got %0d expected %0d", bus.state, S_MEMADR); end
        next_cycle();
        checks++; if (bus.state !== S_MEMWR) begin errors++; $display("FAIL sw_c4_state: got %0d expected %0d", bus.state, S_MEMWR); end
        checks++; if ({bus.IorD, bus.MemWrite, bus.RegWrite, bus.instr_done} !== 4'b1101) begin errors++; $display("FAIL sw_c4_ctl: got %b expected 1101", {bus.IorD, bus.MemWrite, bus.RegWrite, bus.instr_done}); end
        next_cycle();
        checks++; if ({bus.state, bus.MemWrite} !== {S_FETCH, 1'b0}) begin errors++; $display("FAIL sw_end: got %0d/%b expected 0/0", bus.state, bus.MemWrite); end
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic [2:0] exp_ctl);
        bus.opcode = OP_RTYPE;
        bus.funct  = fn;
        next_cycle();
        next_cycle();
        checks++; if (bus.state !== S_EXECUTE) begin errors++; $display("FAIL r_c3_state funct=%b: got %0d expected %0d", fn, bus.state, S_EXECUTE); end
        checks++; if (bus.ALUControl !== exp_ctl) begin errors++; $display("FAIL r_aluctl funct=%b: got %b expected %b", fn, bus.ALUControl, exp_ctl); end
        checks++; if ({bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite} !== 4'b1_00_0) begin errors++; $display("FAIL r_c3_src: got %b expected 1000", {bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite}); end
        next_cycle();
        checks++; if ({bus.RegDst, bus.RegWrite, bus.MemtoReg, bus.instr_done} !== 4'b1101) begin errors++; $display("FAIL r_c4_ctl: got %b expected 1101", {bus.RegDst, bus.RegWrite, bus.MemtoReg, bus.instr_done}); end
        next_cycle();
        checks++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL r_end: got %0d expected %0d", bus.state, S_FETCH); end
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_pcen);
        bus.opcode = op;
        bus.zero   = z;
        next_cycle();
        checks++; if (bus.PCEn !== 1'b0) begin errors++; $display("FAIL br_c2_pcen op=%b: got %b expected 0", op, bus.PCEn); end
        next_cycle();
        checks++; if (bus.state !== S_BRANCH) begin errors++; $display("FAIL br_c3_state op=%b: got %0d expected %0d", op, bus.state, S_BRANCH); end
        checks++; if (bus.PCEn !== exp_pcen) begin errors++; $display("FAIL br_pcen op=%b zero=%b: got %b expected %b", op, z, bus.PCEn, exp_pcen); end
        checks++; if ({bus.PCSrc, bus.ALUControl, bus.ALUSrcA, bus.instr_done} !== 7'b01_110_1_1) begin errors++; $display("FAIL br_c3_ctl: got %b expected 0111011", {bus.PCSrc, bus.ALUControl, bus.ALUSrcA, bus.instr_done}); end
        next_cycle();
        checks++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL br_end: got %0d expected %0d", bus.state, S_FETCH); end
        bus.zero = 1'b0;
    endtask

    task automatic test_addi;
        bus.opcode = OP_ADDI;
        next_cycle();
        next_cycle();
        checks++; if ({bus.state, bus.ALUSrcA, bus.ALUSrcB} !== {S_ADDIEX, 3'b1_10}) begin errors++; $display("FAIL addi_c3: got %0d/%b%b expected 9/110", bus.state, bus.ALUSrcA, bus.ALUSrcB); end
        next_cycle();
        checks++; if ({bus.state, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.instr_done} !== {S_ADDIWB, 4'b1001}) begin errors++; $display("FAIL addi_c4: got %0d/%b expected 10/1001", bus.state, {bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.instr_done}); end
        next_cycle();
    endtask

    task automatic test_jump;
        bus.opcode = OP_J;
        next_cycle();
        next_cycle();
        checks++; if (bus.state !== S_JUMP) begin errors++; $display("FAIL j_c3_state: got %0d expected %0d", bus.state, S_JUMP); end
        checks++; if ({bus.PCSrc, bus.PCEn, bus.instr_done} !== 4'b10_1_1) begin errors++; $display("FAIL j_c3_ctl: got %b expected 1011", {bus.PCSrc, bus.PCEn, bus.instr_done}); end
        next_cycle();
    endtask

    task automatic test_illegal(input logic [5:0] op);
        bus.opcode = op;
        next_cycle();
        checks++; if ({bus.state, bus.illegal_op} !== {S_DECODE, 1'b1}) begin errors++; $display("FAIL illegal_decode op=%b: got %0d/%b expected 1/1", op, bus.state, bus.illegal_op); end
        next_cycle();
        checks++; if ({bus.state, bus.illegal_op, bus.IRWrite} !== {S_FETCH, 2'b01}) begin errors++; $display("FAIL illegal_next op=%b: got %0d/%b%b expected 0/01", op, bus.state, bus.illegal_op, bus.IRWrite); end
    endtask

    task automatic test_bne;
`ifdef CTRL_BNE_EN
        test_branch(OP_BNE, 1'b0, 1'b1);
        test_branch(OP_BNE, 1'b1, 1'b0);
`else
        test_illegal(OP_BNE);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype(FN_SUB, 3'b110);
        test_rtype(FN_ADD, 3'b010);
        test_rtype(FN_AND, 3'b000);
        test_rtype(FN_OR,  3'b001);
        test_rtype(FN_SLT, 3'b111);
        test_rtype(6'b000011, 3'b010);
        test_branch(OP_BEQ, 1'b1, 1'b1);
        test_branch(OP_BEQ, 1'b0, 1'b0);
        test_addi();
        test_jump();
        test_illegal(6'b111111);
        test_bne();
        test_lw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
